// File: rtl/regbank_copy_ctrl.sv
// Block copy sequencer for the 32x32 register bank.
// Moves count words src->dst one per cycle, memmove-safe, yields to stall.
module regbank_copy_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   count,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic              desc_q, desc_d;
  logic              errp_q, errp_d;

  logic [SW-1:0]     src_end;
  logic [SW-1:0]     dst_end;
  logic              range_bad;
  logic              go_desc;
  logic [ADDR_W-1:0] src_last;
  logic [ADDR_W-1:0] dst_last;

  // Range check and direction choice from the raw request inputs
  always_comb begin
    src_end   = SW'(src_base) + SW'(count);
    dst_end   = SW'(dst_base) + SW'(count);
    range_bad = (src_end > SW'(NREGS)) ||
                (dst_end > SW'(NREGS));
    go_desc   = (dst_base > src_base) &&
                (SW'(dst_base) < src_end);
    src_last  = ADDR_W'(src_end - SW'(1));
    dst_last  = ADDR_W'(dst_end - SW'(1));
  end

  // Next-state, pointer stepping and bank port drive
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    desc_d   = desc_q;
    errp_d   = errp_q;
    done     = 1'b0;
    err      = 1'b0;
    rf_we    = 1'b0;
    rf_raddr = '0;
    rf_waddr = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          errp_d = 1'b0;
          if (count == '0) begin
            state_d = FIN;
          end else if (range_bad) begin
            state_d = FIN;
            errp_d  = 1'b1;
          end else begin
            state_d = XFER;
            desc_d  = go_desc;
            src_d   = go_desc ? src_last : src_base;
            dst_d   = go_desc ? dst_last : dst_base;
            rem_d   = count;
          end
        end
      end
      XFER: begin
        rf_raddr = src_q;
        rf_waddr = dst_q;
        rf_we    = !stall;
        if (!stall) begin
          src_d = desc_q ? src_q - AONE : src_q + AONE;
          dst_d = desc_q ? dst_q - AONE : dst_q + AONE;
          rem_d = rem_q - CONE;
          if (rem_q == CONE) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        err     = errp_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write data is the read data, forced to zero when no write is issued
  always_comb begin
    rf_wdata = rf_we ? rf_rdata : '0;
    busy     = (state_q != IDLE);
  end

  // State and copy-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      desc_q  <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      desc_q  <= desc_d;
      errp_q  <= errp_d;
    end
  end

endmodule

// File: tb/tb_regbank_copy_ctrl.sv
// Directed bench for regbank_copy_ctrl with a behavioural 32x32 bank.
// Vector table plus a hand sequence for reset during a copy.
module tb_regbank_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  src_base = '0;
  logic [4:0]  dst_base = '0;
  logic [5:0]  count = '0;
  logic        stall = 1'b0;
  logic        busy, done, err;
  logic [4:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we;

  logic [31:0] rf [32];
  logic [31:0] img [32];
  bit          ld = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          src;
    int          dst;
    int          cnt;
    logic [15:0] smask;
    int          sp;
    int          xerr;
    int          nwr;
    int          nbusy;
    int          first;
    int          last;
  } vec_t;

  vec_t tv [16];

  regbank_copy_ctrl #(
    .DATA_W(32),
    .ADDR_W(5),
    .NREGS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .src_base(src_base),
    .dst_base(dst_base),
    .count(count),
    .stall(stall),
    .busy(busy),
    .done(done),
    .err(err),
    .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++) rf[i] <= img[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata = rf[rf_raddr];

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic preload(input int tag);
    @(negedge clk);
    for (int i = 0; i < 32; i++) img[i] = 32'h1000 + i + (tag << 16);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  function automatic int mem_diff(input logic [31:0] em [32]);
    int d = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== em[i]) d++;
    return d;
  endfunction

  task automatic run(input vec_t v, input int vi);
    int k, nwr, nb, nd, first, last, bad_st, bad_ad, bad_err, errv;
    logic [31:0] em [32];
    logic [31:0] tmp [32];
    string s;
    nwr = 0; nb = 0; nd = 0; first = -1; last = -1;
    bad_st = 0; bad_ad = 0; bad_err = 0; errv = -1;
    preload(vi);
    for (int i = 0; i < 32; i++) em[i] = img[i];
    if (v.xerr == 0) begin
      for (int i = 0; i < v.cnt; i++) tmp[i] = em[v.src + i];
      for (int i = 0; i < v.cnt; i++) em[v.dst + i] = tmp[i];
    end
    src_base = 5'(v.src);
    dst_base = 5'(v.dst);
    count = 6'(v.cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_base = 5'($urandom);
    dst_base = 5'($urandom);
    count = 6'($urandom_range(1, 32));
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      stall = (k < 16) ? v.smask[k] : 1'b0;
      start = (k == v.sp);
      #1;
      if (!busy) break;
      nb++;
      if (rf_we) begin
        if (nwr == 0) first = int'(rf_waddr);
        last = int'(rf_waddr);
        nwr++;
        if (int'(rf_raddr) - int'(rf_waddr) != v.src - v.dst)
          bad_ad++;
      end else if (rf_wdata != 0) begin
        bad_ad++;
      end
      if (stall && rf_we) bad_st++;
      if (done) begin
        nd++;
        errv = int'(err);
      end else if (err) begin
        bad_err++;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    s = $sformatf("v%0d", vi);
    chk({s, " finished"}, int'(k < 80), 1);
    chk({s, " writes"}, nwr, v.nwr);
    chk({s, " busy_cycles"}, nb, v.nbusy);
    chk({s, " done_pulses"}, nd, 1);
    chk({s, " err_at_done"}, errv, v.xerr);
    chk({s, " stray_err"}, bad_err, 0);
    chk({s, " we_in_stall"}, bad_st, 0);
    chk({s, " addr_data"}, bad_ad, 0);
    if (v.nwr > 0) begin
      chk({s, " first_waddr"}, first, v.first);
      chk({s, " last_waddr"}, last, v.last);
    end
    chk({s, " bank_words_wrong"}, mem_diff(em), 0);
    @(negedge clk);
    #1;
    chk({s, " idle_after"}, int'(busy), 0);
  endtask

  initial begin
    logic [31:0] em [32];
    vec_t rv;
    tv[0]  = '{2, 20, 4, 16'h0, -1, 0, 4, 5, 20, 23};
    tv[1]  = '{4, 6, 5, 16'h0, -1, 0, 5, 6, 10, 6};
    tv[2]  = '{6, 4, 5, 16'h0, -1, 0, 5, 6, 4, 8};
    tv[3]  = '{3, 5, 0, 16'h0, -1, 0, 0, 1, 0, 0};
    tv[4]  = '{30, 0, 3, 16'h0, -1, 1, 0, 1, 0, 0};
    tv[5]  = '{29, 0, 3, 16'h0, -1, 0, 3, 4, 0, 2};
    tv[6]  = '{5, 5, 3, 16'h0, -1, 0, 3, 4, 5, 7};
    tv[7]  = '{0, 0, 32, 16'h0, -1, 0, 32, 33, 0, 31};
    tv[8]  = '{0, 1, 31, 16'h0, -1, 0, 31, 32, 31, 1};
    tv[9]  = '{1, 0, 32, 16'h0, -1, 1, 0, 1, 0, 0};
    tv[10] = '{10, 25, 8, 16'h0, -1, 1, 0, 1, 0, 0};
    tv[11] = '{2, 12, 3, 16'h000e, -1, 0, 3, 7, 12, 14};
    tv[12] = '{8, 9, 4, 16'h0, 1, 0, 4, 5, 12, 9};
    tv[13] = '{1, 3, 2, 16'h0, 2, 0, 2, 3, 3, 4};
    tv[14] = '{31, 31, 1, 16'h0, -1, 0, 1, 2, 31, 31};
    tv[15] = '{0, 31, 1, 16'h0, -1, 0, 1, 2, 31, 31};

    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done_err", int'({done, err}), 0);
    chk("reset we", int'(rf_we), 0);
    chk("reset addrs", int'({rf_raddr, rf_waddr}), 0);
    chk("reset wdata", int'(rf_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run(tv[i], i);

    preload(40);
    for (int i = 0; i < 32; i++) em[i] = img[i];
    em[16] = img[0];
    em[17] = img[1];
    src_base = 5'd0;
    dst_base = 5'd16;
    count = 6'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst we", int'(rf_we), 0);
    chk("rst done", int'(done), 0);
    chk("rst waddr", int'(rf_waddr), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst busy_held", int'(busy), 0);
    chk("rst words_wrong", mem_diff(em), 0);
    rst_n = 1'b1;
    rv = '{7, 3, 1, 16'h0, -1, 0, 1, 2, 3, 3};
    run(rv, 41);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
